// File: rtl/serial_add_seq.sv
// ============================================================================
// serial_add_seq
// ----------------------------------------------------------------------------
// Bit-serial adder sequencer. Accepts a pair of WIDTH-bit operands over a
// valid/ready handshake, then clocks a single 1-bit full-adder cell LSB-first
// for WIDTH cycles with the carry held in a flop. The WIDTH-bit sum and the
// carry-out are returned over a second valid/ready handshake.
//
// Configuration macro:
//   SERIAL_ADD_SUB_EN - adds the 'sub' port. With sub=1 at accept the block
//                       computes (a - b) mod 2^WIDTH by loading ~b and a
//                       forced carry-in of 1; cout then reads as "no borrow".
//
// Parameters:
//   WIDTH      - operand/result width in bits (>= 2).
//
// Ports:
//   clk        - rising-edge clock.
//   rst_n      - asynchronous active-low reset.
//   in_valid   - operands (and mode) present.
//   in_ready   - block can accept operands (state is IDLE).
//   a, b       - WIDTH-bit operands, sampled only on the accept edge.
//   cin        - carry-in, sampled only on the accept edge.
//   sub        - subtract mode (only with SERIAL_ADD_SUB_EN).
//   out_valid  - result valid (state is DONE).
//   out_ready  - consumer accepts the result.
//   sum        - registered WIDTH-bit result.
//   cout       - registered carry-out / no-borrow flag.
//   busy       - serial addition in progress (state is RUN).
// ============================================================================
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    // The shared full-adder cell
    logic fa_s;
    logic fa_c;
    logic last_bit;

    // Operand B and carry-in as presented to the shift register at accept
    logic [WIDTH-1:0] b_load;
    logic             cin_load;

    always_comb begin
        fa_s = sa_q[0] ^ sb_q[0] ^ carry_q;
        fa_c = (sa_q[0] & sb_q[0]) | (sa_q[0] & carry_q) | (sb_q[0] & carry_q);
    end

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef SERIAL_ADD_SUB_EN
    // Two's-complement subtract: a + ~b + 1; the external carry-in is ignored.
    always_comb begin
        b_load   = sub ? ~b : b;
        cin_load = sub ? 1'b1 : cin;
    end
`else
    always_comb begin
        b_load   = b;
        cin_load = cin;
    end
`endif

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sa_d    = a;
                    sb_d    = b_load;
                    carry_d = cin_load;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                sa_d    = {1'b0, sa_q[WIDTH-1:1]};
                sb_d    = {1'b0, sb_q[WIDTH-1:1]};
                // Sum bits enter at the MSB so that after WIDTH shifts the
                // first (LSB) bit has reached position 0.
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                carry_d = fa_c;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    sum_d   = {fa_s, res_q[WIDTH-1:1]};
                    cout_d  = fa_c;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_RUN);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// ============================================================================
// tb_serial_add_seq
// ----------------------------------------------------------------------------
// Directed self-checking bench for serial_add_seq (WIDTH=8). Expected values
// are hand-computed constants. Subtract vectors run only when
// SERIAL_ADD_SUB_EN is defined.
// ============================================================================
module tb_serial_add_seq;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    int n_checks;
    int n_fails;

    serial_add_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One operation: accept, scramble inputs during RUN, check latency/busy,
    // then hold the result for 'hold' cycles of backpressure before release.
    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                          input logic tc, input logic tsub, input logic [7:0] exp_sum,
                          input logic exp_cout, input int hold);
        int cyc;
        int busy_cnt;
        @(negedge clk);
        a = ta; b = tb; cin = tc; sub = tsub;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        check({tag, "_in_ready"}, in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        busy_cnt = 0;
        while (!out_valid && cyc < 40) begin
            if (busy) busy_cnt++;
            a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, cyc, WIDTH);
        check({tag, "_busy_cycles"}, busy_cnt, WIDTH);
        check({tag, "_sum"}, sum, exp_sum);
        check({tag, "_cout"}, cout, exp_cout);
        check({tag, "_busy_done"}, busy, 1'b0);
        check({tag, "_in_ready_done"}, in_ready, 1'b0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;  // must be ignored in DONE
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, out_valid, 1'b1);
            check({tag, "_hold_sum"}, sum, exp_sum);
            check({tag, "_hold_cout"}, cout, exp_cout);
            check({tag, "_hold_in_ready"}, in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_idle_in_ready"}, in_ready, 1'b1);
        check({tag, "_idle_out_valid"}, out_valid, 1'b0);
        check({tag, "_idle_sum"}, sum, exp_sum);
    endtask

    logic [7:0] bb_a    [4] = '{8'h01, 8'hF0, 8'h7F, 8'hAA};
    logic [7:0] bb_b    [4] = '{8'h01, 8'h20, 8'h00, 8'h55};
    logic       bb_cin  [4] = '{1'b0,  1'b0,  1'b1,  1'b1};
    logic [7:0] bb_sum  [4] = '{8'h02, 8'h10, 8'h80, 8'h00};
    logic       bb_cout [4] = '{1'b0,  1'b1,  1'b0,  1'b1};

    initial begin
        int cyc;
        int acc;
        int res;
        int last_acc;
        logic fire;

        n_checks = 0;
        n_fails  = 0;
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        a = 8'h11; b = 8'h22; cin = 1'b0; sub = 1'b0;

        // Reset state, with in_valid high across edges that must be ignored
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sum", sum, 8'h00);
        check("rst_cout", cout, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;

        run_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 0);

        // Abort mid-RUN after bit 3 has been processed
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("abort_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_sum", sum, 8'h00);
        check("abort_cout", cout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) cyc++;
        end
        check("abort_no_valid_pulse", cyc, 0);

        run_op("add_01_02", 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 0);
        run_op("add_80_80_bp", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 5);

`ifdef SERIAL_ADD_SUB_EN
        run_op("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 0);
        run_op("sub_00_01", 8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0, 0);
`endif

        // Back-to-back with in_valid held high
        @(negedge clk);
        a = bb_a[0]; b = bb_b[0]; cin = bb_cin[0]; sub = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        cyc = 0; acc = 0; res = 0; last_acc = 0;
        while ((acc < 4 || res < 4) && cyc < 200) begin
            fire = in_valid && in_ready;
            if (out_valid && res < 4) begin
                check("b2b_sum", sum, bb_sum[res]);
                check("b2b_cout", cout, bb_cout[res]);
                res++;
            end
            if (fire) begin
                if (acc > 0) check("b2b_spacing", cyc - last_acc, WIDTH + 2);
                last_acc = cyc;
                acc++;
            end
            @(posedge clk); #1;
            if (fire) begin
                if (acc < 4) begin
                    a = bb_a[acc]; b = bb_b[acc]; cin = bb_cin[acc];
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        check("b2b_accepts", acc, 4);
        check("b2b_results", res, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
